// File: rtl/mdu_rvs.sv
// mdu_rvs: reservation station for the multiply/divide unit.
// Holds up to DEPTH ops between dispatch and MDU execute, snoops the CDB
// for operand wakeup and issues the lowest-index ready op over a req/rdy
// handshake. Once presented, an op stays selected until the MDU accepts it.
// Optional build macro: MDU_RVS_WAKEUP_BYPASS_EN -- an entry whose last
// missing operand(s) match the current CDB broadcast counts as ready in that
// same cycle and forwards cdb_wdata on iss_src1/iss_src2.
module mdu_rvs #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       disp_req,
    output logic                       disp_rdy,
    input  logic [2:0]                 disp_opc,
    input  logic [TAG_W-1:0]           disp_tag,
    input  logic                       disp_src1_rdy,
    input  logic [TAG_W-1:0]           disp_src1_tag,
    input  logic [DATA_W-1:0]          disp_src1,
    input  logic                       disp_src2_rdy,
    input  logic [TAG_W-1:0]           disp_src2_tag,
    input  logic [DATA_W-1:0]          disp_src2,
    input  logic                       cdb_vld,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_wdata,
    output logic                       iss_req,
    input  logic                       iss_rdy,
    output logic [2:0]                 iss_opc,
    output logic [TAG_W-1:0]           iss_tag,
    output logic [DATA_W-1:0]          iss_src1,
    output logic [DATA_W-1:0]          iss_src2,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH+1);

    // Entry storage
    logic [DEPTH-1:0]  valid_r;
    logic [2:0]        opc_r    [DEPTH];
    logic [TAG_W-1:0]  tag_r    [DEPTH];
    logic [DEPTH-1:0]  s1_rdy_r;
    logic [TAG_W-1:0]  s1_tag_r [DEPTH];
    logic [DATA_W-1:0] s1_val_r [DEPTH];
    logic [DEPTH-1:0]  s2_rdy_r;
    logic [TAG_W-1:0]  s2_tag_r [DEPTH];
    logic [DATA_W-1:0] s2_val_r [DEPTH];
    logic [OCC_W-1:0]  occ_r;

    // Held-selection lock: keeps the presented op stable while the MDU stalls
    logic              lock_vld_r;
    logic [IDX_W-1:0]  lock_idx_r;

    logic [DEPTH-1:0]  s1_hit_s;
    logic [DEPTH-1:0]  s2_hit_s;
    logic [DEPTH-1:0]  ready_s;
    logic              any_rdy_s;
    logic [IDX_W-1:0]  pick_idx_s;
    logic [IDX_W-1:0]  sel_idx_s;
    logic              iss_req_s;
    logic              any_free_s;
    logic [IDX_W-1:0]  free_idx_s;
    logic              do_disp_s;
    logic              do_iss_s;
    logic              d1_rdy_s;
    logic              d2_rdy_s;
    logic [DATA_W-1:0] d1_val_s;
    logic [DATA_W-1:0] d2_val_s;

    // Per-entry CDB tag match and readiness
    always_comb begin
        s1_hit_s = '0;
        s2_hit_s = '0;
        ready_s  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            s1_hit_s[i] = valid_r[i] && !s1_rdy_r[i] && cdb_vld && (s1_tag_r[i] == cdb_tag);
            s2_hit_s[i] = valid_r[i] && !s2_rdy_r[i] && cdb_vld && (s2_tag_r[i] == cdb_tag);
`ifdef MDU_RVS_WAKEUP_BYPASS_EN
            ready_s[i]  = valid_r[i] && (s1_rdy_r[i] || s1_hit_s[i]) && (s2_rdy_r[i] || s2_hit_s[i]);
`else
            ready_s[i]  = valid_r[i] && s1_rdy_r[i] && s2_rdy_r[i];
`endif
        end
    end

    // Lowest-index ready entry and lowest-index free entry
    always_comb begin
        any_rdy_s  = 1'b0;
        pick_idx_s = '0;
        any_free_s = 1'b0;
        free_idx_s = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (ready_s[i]) begin
                any_rdy_s  = 1'b1;
                pick_idx_s = IDX_W'(i);
            end else begin
                pick_idx_s = pick_idx_s;
            end
            if (!valid_r[i]) begin
                any_free_s = 1'b1;
                free_idx_s = IDX_W'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
    end

    // Issue selection: a stalled op keeps priority over newly ready lower entries
    always_comb begin
        sel_idx_s = pick_idx_s;
        iss_req_s = any_rdy_s;
        if (lock_vld_r) begin
            sel_idx_s = lock_idx_r;
            iss_req_s = ready_s[lock_idx_r];
        end else begin
            sel_idx_s = pick_idx_s;
            iss_req_s = any_rdy_s;
        end
    end

    // Dispatch operand capture, including wakeup from a same-cycle broadcast
    always_comb begin
        d1_rdy_s = disp_src1_rdy || (cdb_vld && (disp_src1_tag == cdb_tag));
        d2_rdy_s = disp_src2_rdy || (cdb_vld && (disp_src2_tag == cdb_tag));
        d1_val_s = disp_src1_rdy ? disp_src1 : cdb_wdata;
        d2_val_s = disp_src2_rdy ? disp_src2 : cdb_wdata;
        do_disp_s = disp_req && any_free_s && !flush;
        do_iss_s  = iss_req_s && iss_rdy;
    end

    // Issue port drive; fields forced to zero when nothing is presented
    always_comb begin
        iss_req  = iss_req_s;
        iss_opc  = 3'b000;
        iss_tag  = '0;
        iss_src1 = '0;
        iss_src2 = '0;
        if (iss_req_s) begin
            iss_opc  = opc_r[sel_idx_s];
            iss_tag  = tag_r[sel_idx_s];
            iss_src1 = s1_val_r[sel_idx_s];
            iss_src2 = s2_val_r[sel_idx_s];
`ifdef MDU_RVS_WAKEUP_BYPASS_EN
            if (s1_hit_s[sel_idx_s]) begin
                iss_src1 = cdb_wdata;
            end else begin
                iss_src1 = s1_val_r[sel_idx_s];
            end
            if (s2_hit_s[sel_idx_s]) begin
                iss_src2 = cdb_wdata;
            end else begin
                iss_src2 = s2_val_r[sel_idx_s];
            end
`endif
        end else begin
            iss_opc  = 3'b000;
        end
        disp_rdy  = any_free_s;
        occupancy = occ_r;
    end

    // Entry state: dispatch write, CDB capture, free on transfer, flush squash
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r  <= '0;
            s1_rdy_r <= '0;
            s2_rdy_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                opc_r[i]    <= 3'b000;
                tag_r[i]    <= '0;
                s1_tag_r[i] <= '0;
                s1_val_r[i] <= '0;
                s2_tag_r[i] <= '0;
                s2_val_r[i] <= '0;
            end
        end else if (flush) begin
            valid_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (s1_hit_s[i]) begin
                    s1_rdy_r[i] <= 1'b1;
                    s1_val_r[i] <= cdb_wdata;
                end
                if (s2_hit_s[i]) begin
                    s2_rdy_r[i] <= 1'b1;
                    s2_val_r[i] <= cdb_wdata;
                end
                if (do_iss_s && (sel_idx_s == IDX_W'(i))) begin
                    valid_r[i] <= 1'b0;
                end
                if (do_disp_s && (free_idx_s == IDX_W'(i))) begin
                    valid_r[i]  <= 1'b1;
                    opc_r[i]    <= disp_opc;
                    tag_r[i]    <= disp_tag;
                    s1_rdy_r[i] <= d1_rdy_s;
                    s1_tag_r[i] <= disp_src1_tag;
                    s1_val_r[i] <= d1_val_s;
                    s2_rdy_r[i] <= d2_rdy_s;
                    s2_tag_r[i] <= disp_src2_tag;
                    s2_val_r[i] <= d2_val_s;
                end
            end
        end
    end

    // Occupancy counter and stalled-issue lock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_r      <= '0;
            lock_vld_r <= 1'b0;
            lock_idx_r <= '0;
        end else if (flush) begin
            occ_r      <= '0;
            lock_vld_r <= 1'b0;
            lock_idx_r <= '0;
        end else begin
            case ({do_disp_s, do_iss_s})
                2'b10:   occ_r <= occ_r + OCC_W'(1);
                2'b01:   occ_r <= occ_r - OCC_W'(1);
                default: occ_r <= occ_r;
            endcase
            lock_vld_r <= iss_req_s && !iss_rdy;
            lock_idx_r <= sel_idx_s;
        end
    end

endmodule

// File: tb/tb_mdu_rvs.sv
// tb_mdu_rvs: directed self-checking bench for mdu_rvs (DEPTH=4, TAG_W=4, DATA_W=32).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// after a further settle delay, well away from the next edge.
module tb_mdu_rvs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        disp_req = 1'b0;
    logic        disp_rdy;
    logic [2:0]  disp_opc = 3'd0;
    logic [3:0]  disp_tag = 4'd0;
    logic        disp_src1_rdy = 1'b0;
    logic [3:0]  disp_src1_tag = 4'd0;
    logic [31:0] disp_src1 = 32'd0;
    logic        disp_src2_rdy = 1'b0;
    logic [3:0]  disp_src2_tag = 4'd0;
    logic [31:0] disp_src2 = 32'd0;
    logic        cdb_vld = 1'b0;
    logic [3:0]  cdb_tag = 4'd0;
    logic [31:0] cdb_wdata = 32'd0;
    logic        iss_req;
    logic        iss_rdy = 1'b0;
    logic [2:0]  iss_opc;
    logic [3:0]  iss_tag;
    logic [31:0] iss_src1;
    logic [31:0] iss_src2;
    logic [2:0]  occupancy;

    int total = 0;
    int bad   = 0;

    mdu_rvs #(.DEPTH(4), .TAG_W(4), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_req(disp_req), .disp_rdy(disp_rdy), .disp_opc(disp_opc), .disp_tag(disp_tag),
        .disp_src1_rdy(disp_src1_rdy), .disp_src1_tag(disp_src1_tag), .disp_src1(disp_src1),
        .disp_src2_rdy(disp_src2_rdy), .disp_src2_tag(disp_src2_tag), .disp_src2(disp_src2),
        .cdb_vld(cdb_vld), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata),
        .iss_req(iss_req), .iss_rdy(iss_rdy), .iss_opc(iss_opc), .iss_tag(iss_tag),
        .iss_src1(iss_src1), .iss_src2(iss_src2), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [2:0] opc, input logic [3:0] tag,
                        input logic r1, input logic [3:0] t1, input logic [31:0] v1,
                        input logic r2, input logic [3:0] t2, input logic [31:0] v2);
        disp_req = 1'b1; disp_opc = opc; disp_tag = tag;
        disp_src1_rdy = r1; disp_src1_tag = t1; disp_src1 = v1;
        disp_src2_rdy = r2; disp_src2_tag = t2; disp_src2 = v2;
    endtask

    initial begin
        // reset state
        #2;
        check_eq("rst_disp_rdy", {31'd0, disp_rdy}, 32'd1);
        check_eq("rst_iss_req", {31'd0, iss_req}, 32'd0);
        check_eq("rst_occ", {29'd0, occupancy}, 32'd0);
        check_eq("rst_iss_tag", {28'd0, iss_tag}, 32'd0);
        step(); step();
        rst = 1'b0;

        // basic mul: issue next cycle, entry freed
        iss_rdy = 1'b1;
        disp(3'd0, 4'd3, 1'b1, 4'd0, 32'd6, 1'b1, 4'd0, 32'd7);
        step();
        disp_req = 1'b0; #1;
        check_eq("mul_occ1", {29'd0, occupancy}, 32'd1);
        check_eq("mul_req", {31'd0, iss_req}, 32'd1);
        check_eq("mul_opc", {29'd0, iss_opc}, 32'd0);
        check_eq("mul_tag", {28'd0, iss_tag}, 32'd3);
        check_eq("mul_src1", iss_src1, 32'd6);
        check_eq("mul_src2", iss_src2, 32'd7);
        step();
        check_eq("mul_occ0", {29'd0, occupancy}, 32'd0);
        check_eq("mul_req0", {31'd0, iss_req}, 32'd0);

        // div waiting on tag 5, woken by CDB two cycles later
        iss_rdy = 1'b0;
        disp(3'd4, 4'd2, 1'b0, 4'd5, 32'd0, 1'b1, 4'd0, 32'd9);
        step();
        disp_req = 1'b0; #1;
        check_eq("div_occ", {29'd0, occupancy}, 32'd1);
        check_eq("div_wait", {31'd0, iss_req}, 32'd0);
        step();
        cdb_vld = 1'b1; cdb_tag = 4'd5; cdb_wdata = 32'h64; #1;
`ifdef MDU_RVS_WAKEUP_BYPASS_EN
        check_eq("div_byp_req", {31'd0, iss_req}, 32'd1);
        check_eq("div_byp_src1", iss_src1, 32'h64);
`else
        check_eq("div_nobyp_req", {31'd0, iss_req}, 32'd0);
`endif
        step();
        cdb_vld = 1'b0; #1;
        check_eq("div_req", {31'd0, iss_req}, 32'd1);
        check_eq("div_src1", iss_src1, 32'h64);
        check_eq("div_src2", iss_src2, 32'd9);
        check_eq("div_tag", {28'd0, iss_tag}, 32'd2);
        check_eq("div_opc", {29'd0, iss_opc}, 32'd4);
        iss_rdy = 1'b1;
        step();
        check_eq("div_done_occ", {29'd0, occupancy}, 32'd0);

        // fill all four entries with waiting ops
        for (int k = 0; k < 4; k++) begin
            disp(3'd5, 4'(k), 1'b0, 4'(8 + k), 32'd0, 1'b1, 4'd0, 32'h40 + 32'(k));
            step();
            check_eq("fill_occ", {29'd0, occupancy}, 32'(k + 1));
        end
        disp_req = 1'b0; #1;
        check_eq("full_disp_rdy", {31'd0, disp_rdy}, 32'd0);
        check_eq("full_iss_req", {31'd0, iss_req}, 32'd0);
        cdb_vld = 1'b1; cdb_tag = 4'd10; cdb_wdata = 32'h10; #1;
`ifdef MDU_RVS_WAKEUP_BYPASS_EN
        check_eq("wake2_byp_tag", {28'd0, iss_tag}, 32'd2);
        check_eq("wake2_byp_src1", iss_src1, 32'h10);
        step();
        cdb_vld = 1'b0; #1;
`else
        check_eq("wake2_req0", {31'd0, iss_req}, 32'd0);
        step();
        cdb_vld = 1'b0; #1;
        check_eq("wake2_req", {31'd0, iss_req}, 32'd1);
        check_eq("wake2_tag", {28'd0, iss_tag}, 32'd2);
        check_eq("wake2_src1", iss_src1, 32'h10);
        check_eq("wake2_src2", iss_src2, 32'h42);
        check_eq("wake2_full", {31'd0, disp_rdy}, 32'd0);
        step();
`endif
        check_eq("freed_occ", {29'd0, occupancy}, 32'd3);
        check_eq("freed_disp_rdy", {31'd0, disp_rdy}, 32'd1);
        disp(3'd3, 4'd12, 1'b1, 4'd0, 32'h11, 1'b1, 4'd0, 32'h22);
        step();
        disp_req = 1'b0; #1;
        check_eq("reuse_full", {31'd0, disp_rdy}, 32'd0);
        check_eq("reuse_occ", {29'd0, occupancy}, 32'd4);
        check_eq("reuse_tag", {28'd0, iss_tag}, 32'd12);
        check_eq("reuse_src1", iss_src1, 32'h11);
        step();
        check_eq("reuse_iss_occ", {29'd0, occupancy}, 32'd3);

        // flush with three waiting entries; same-cycle dispatch dropped
        flush = 1'b1;
        disp(3'd0, 4'd13, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1);
        step();
        flush = 1'b0; disp_req = 1'b0; #1;
        check_eq("flush_occ", {29'd0, occupancy}, 32'd0);
        check_eq("flush_req", {31'd0, iss_req}, 32'd0);
        check_eq("flush_disp_rdy", {31'd0, disp_rdy}, 32'd1);

        // dispatch-cycle wakeup, then held issue for five cycles
        iss_rdy = 1'b0;
        disp(3'd1, 4'd6, 1'b1, 4'd0, 32'd1, 1'b0, 4'd7, 32'd0);
        cdb_vld = 1'b1; cdb_tag = 4'd7; cdb_wdata = 32'hA5;
        step();
        disp_req = 1'b0; cdb_vld = 1'b0; #1;
        check_eq("dw_req", {31'd0, iss_req}, 32'd1);
        check_eq("dw_src2", iss_src2, 32'hA5);
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("hold_req", {31'd0, iss_req}, 32'd1);
            check_eq("hold_tag", {28'd0, iss_tag}, 32'd6);
            check_eq("hold_opc", {29'd0, iss_opc}, 32'd1);
            check_eq("hold_src1", iss_src1, 32'd1);
            check_eq("hold_src2", iss_src2, 32'hA5);
        end
        iss_rdy = 1'b1;
        step();
        check_eq("hold_done_occ", {29'd0, occupancy}, 32'd0);
        check_eq("hold_done_req", {31'd0, iss_req}, 32'd0);

        // same-edge dispatch and issue keeps occupancy
        iss_rdy = 1'b0;
        disp(3'd7, 4'd1, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0, 32'd4);
        step();
        check_eq("se_occ1", {29'd0, occupancy}, 32'd1);
        disp(3'd6, 4'd4, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd6);
        iss_rdy = 1'b1;
        step();
        disp_req = 1'b0; iss_rdy = 1'b0; #1;
        check_eq("se_occ_same", {29'd0, occupancy}, 32'd1);
        check_eq("se_tag", {28'd0, iss_tag}, 32'd4);
        disp(3'd2, 4'd9, 1'b1, 4'd0, 32'd8, 1'b1, 4'd0, 32'd8);
        step();
        disp_req = 1'b0; #1;
        check_eq("pre_rst_occ", {29'd0, occupancy}, 32'd2);
        check_eq("pre_rst_req", {31'd0, iss_req}, 32'd1);

        // asynchronous reset between clock edges
        #1; rst = 1'b1; #1;
        check_eq("arst_req", {31'd0, iss_req}, 32'd0);
        check_eq("arst_occ", {29'd0, occupancy}, 32'd0);
        check_eq("arst_disp_rdy", {31'd0, disp_rdy}, 32'd1);
        check_eq("arst_tag", {28'd0, iss_tag}, 32'd0);
        check_eq("arst_src1", iss_src1, 32'd0);
        step();
        rst = 1'b0;
        step();
        check_eq("post_rst_occ", {29'd0, occupancy}, 32'd0);
        check_eq("post_rst_req", {31'd0, iss_req}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
